// File: rtl/alu_protocol_checker.sv
// Protocol checker for the ALU: operand pairing, ce hold, post-reset output and
// illegal-command error checks, reported as registered pulses, sticky flags and counters.
//
//   state  | meaning
//   IDLE   | no operand outstanding
//   WAIT_A | opb seen, waiting for opa under the captured mode/cmd
//   WAIT_B | opa seen, waiting for opb under the captured mode/cmd
module alu_protocol_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int RES_WIDTH  = 2*DATA_WIDTH,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   mode,
    input  logic                   cin,
    input  logic [DATA_WIDTH-1:0]  opa,
    input  logic [DATA_WIDTH-1:0]  opb,
    input  logic [1:0]             inp_valid,
    input  logic [CMD_WIDTH-1:0]   cmd,
    input  logic [RES_WIDTH-1:0]   res,
    input  logic                   cout,
    input  logic                   oflow,
    input  logic                   g,
    input  logic                   l,
    input  logic                   e,
    input  logic                   err,
    input  logic                   clr_sticky,
    output logic [4:0]             viol,
    output logic [4:0]             viol_sticky,
    output logic [5*CNT_WIDTH-1:0] viol_cnt,
    output logic [1:0]             pair_state
);

    localparam int OUT_W = RES_WIDTH + 6;
    localparam int NV    = 5;
    localparam logic [7:0]           WAIT_TC = 8'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2
    } pair_state_t;

    pair_state_t            state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic                   cap_mode_q, cap_mode_d;
    logic [CMD_WIDTH-1:0]   cap_cmd_q, cap_cmd_d;

    logic [OUT_W-1:0]       out_vec;
    logic [OUT_W-1:0]       prev_out;
    logic [31:0]            cmd_ext;
    logic                   two_op;
    logic                   illegal;
    logic                   first_edge;
    logic                   hold_arm;
    logic                   err_arm;
    logic                   awaited;
    logic                   pair_timeout;
    logic                   pair_cmd_change;
    logic [NV-1:0]          viol_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NV];

    // Operands and carry-in do not take part in any check.
    logic unused_inputs;
    assign unused_inputs = ^{opa, opb, cin};

    assign out_vec = {res, cout, oflow, g, l, e, err};
    assign cmd_ext = 32'(cmd);

    always_comb begin
        two_op  = 1'b0;
        illegal = 1'b0;
        if (mode) begin
            two_op  = (cmd_ext <= 32'd3) || ((cmd_ext >= 32'd8) && (cmd_ext <= 32'd10));
            illegal = (cmd_ext > 32'd10);
        end else begin
            two_op  = (cmd_ext <= 32'd5) || (cmd_ext == 32'd12) || (cmd_ext == 32'd13);
            illegal = (cmd_ext > 32'd13);
        end
    end

    // Single-edge history feeding the next-edge checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_edge <= 1'b1;
            hold_arm   <= 1'b0;
            prev_out   <= '0;
            err_arm    <= 1'b0;
        end else begin
            first_edge <= 1'b0;
            hold_arm   <= !ce && !first_edge;
            prev_out   <= out_vec;
            err_arm    <= ce && (inp_valid != 2'b00) && illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            cap_mode_q <= 1'b0;
            cap_cmd_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cap_mode_q <= cap_mode_d;
            cap_cmd_q  <= cap_cmd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        cap_mode_d      = cap_mode_q;
        cap_cmd_d       = cap_cmd_q;
        awaited         = 1'b0;
        pair_timeout    = 1'b0;
        pair_cmd_change = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce && two_op) begin
                    if (inp_valid == 2'b01) begin
                        state_d    = WAIT_B;
                        cap_mode_d = mode;
                        cap_cmd_d  = cmd;
                        wait_cnt_d = '0;
                    end else if (inp_valid == 2'b10) begin
                        state_d    = WAIT_A;
                        cap_mode_d = mode;
                        cap_cmd_d  = cmd;
                        wait_cnt_d = '0;
                    end
                end
            end
            WAIT_A, WAIT_B: begin
                // ce low freezes both the state and the wait counter.
                if (ce) begin
                    awaited = (state_q == WAIT_A) ? inp_valid[0] : inp_valid[1];
                    if ((mode != cap_mode_q) || (cmd != cap_cmd_q)) begin
                        pair_cmd_change = 1'b1;
                        state_d         = IDLE;
                    end else if (awaited) begin
                        state_d = IDLE;
                    end else if (wait_cnt_q == WAIT_TC) begin
                        pair_timeout = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign viol_d[0] = hold_arm && (out_vec != prev_out);
    assign viol_d[1] = first_edge && (out_vec != '0);
    assign viol_d[2] = pair_timeout;
    assign viol_d[3] = pair_cmd_change;
    assign viol_d[4] = err_arm && !err;

    // Clear takes effect before this edge's violations accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol        <= '0;
            viol_sticky <= '0;
            for (int k = 0; k < NV; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            viol        <= viol_d;
            viol_sticky <= (clr_sticky ? '0 : viol_sticky) | viol_d;
            for (int k = 0; k < NV; k++) begin
                if (clr_sticky) begin
                    cnt_q[k] <= viol_d[k] ? CNT_ONE : '0;
                end else if (viol_d[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    for (genvar gk = 0; gk < NV; gk++) begin : g_cnt
        assign viol_cnt[gk*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gk];
    end

    assign pair_state = state_q;

endmodule

// File: tb/tb_alu_protocol_checker.sv
// Self-checking bench for alu_protocol_checker: directed plan steps followed by
// randomized traffic, every edge compared against a behavioural model.
module tb_alu_protocol_checker;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int RW  = 2*DW;
    localparam int TO  = 16;
    localparam int CNW = 8;
    localparam int CNT_MAX = (1 << CNW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ce, mode, cin;
    logic [DW-1:0]  opa, opb;
    logic [1:0]     inp_valid;
    logic [CW-1:0]  cmd;
    logic [RW-1:0]  res;
    logic           cout, oflow, g, l, e, err, clr_sticky;
    logic [4:0]     viol, viol_sticky;
    logic [5*CNW-1:0] viol_cnt;
    logic [1:0]     pair_state;

    alu_protocol_checker #(
        .DATA_WIDTH(DW), .CMD_WIDTH(CW), .RES_WIDTH(RW), .TIMEOUT(TO), .CNT_WIDTH(CNW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin),
        .opa(opa), .opb(opb), .inp_valid(inp_valid), .cmd(cmd), .res(res),
        .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e), .err(err),
        .clr_sticky(clr_sticky), .viol(viol), .viol_sticky(viol_sticky),
        .viol_cnt(viol_cnt), .pair_state(pair_state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: what is outstanding, not how the RTL encodes it.
    bit             m_first;
    bit             m_hold_arm;
    logic [RW+5:0]  m_prev_out;
    bit             m_err_arm;
    int             m_await;
    int             m_waited;
    logic           m_mode;
    logic [CW-1:0]  m_cmd;
    logic [4:0]     m_viol;
    logic [4:0]     m_sticky;
    int             m_cnt [5];

    function automatic bit is_two_op(logic md, int c);
        if (md) return c inside {0, 1, 2, 3, 8, 9, 10};
        return c inside {[0:5], 12, 13};
    endfunction

    function automatic bit is_illegal(logic md, int c);
        return c > (md ? 10 : 13);
    endfunction

    task automatic model_edge();
        logic [RW+5:0] o;
        logic [4:0]    v;
        int            c;
        if (rst) begin
            m_first    = 1;
            m_hold_arm = 0;
            m_err_arm  = 0;
            m_await    = 0;
            m_waited   = 0;
            m_viol     = '0;
            m_sticky   = '0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
            return;
        end
        o = {res, cout, oflow, g, l, e, err};
        c = int'(cmd);
        v = '0;
        if (m_first && (o != '0)) v[1] = 1'b1;
        if (m_hold_arm && (o != m_prev_out)) v[0] = 1'b1;
        if (m_err_arm && !err) v[4] = 1'b1;
        if (m_await != 0) begin
            if (ce) begin
                if ((mode !== m_mode) || (cmd !== m_cmd)) begin
                    v[3] = 1'b1;
                    m_await = 0;
                end else if ((m_await == 1) ? inp_valid[0] : inp_valid[1]) begin
                    m_await = 0;
                end else if (m_waited + 1 >= TO) begin
                    v[2] = 1'b1;
                    m_await = 0;
                end else begin
                    m_waited++;
                end
            end
        end else if (ce && is_two_op(mode, c) && (inp_valid == 2'b01 || inp_valid == 2'b10)) begin
            m_await  = (inp_valid == 2'b01) ? 2 : 1;
            m_waited = 0;
            m_mode   = mode;
            m_cmd    = cmd;
        end
        m_hold_arm = !ce && !m_first;
        m_prev_out = o;
        m_err_arm  = ce && (inp_valid != 2'b00) && is_illegal(mode, c);
        m_first    = 0;
        for (int k = 0; k < 5; k++) begin
            if (clr_sticky) begin
                m_sticky[k] = v[k];
                m_cnt[k]    = v[k] ? 1 : 0;
            end else begin
                m_sticky[k] = m_sticky[k] | v[k];
                if (v[k] && m_cnt[k] < CNT_MAX) m_cnt[k]++;
            end
        end
        m_viol = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("viol", 64'(viol), 64'(m_viol));
        check("viol_sticky", 64'(viol_sticky), 64'(m_sticky));
        for (int k = 0; k < 5; k++)
            check($sformatf("viol_cnt[%0d]", k), 64'(viol_cnt[k*CNW +: CNW]), 64'(m_cnt[k]));
        check("pair_state", 64'(pair_state), 64'(m_await));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        ce = 1; mode = 0; cin = 0; opa = '0; opb = '0; inp_valid = 2'b00; cmd = '0;
        res = '0; cout = 0; oflow = 0; g = 0; l = 0; e = 0; err = 0; clr_sticky = 0;
        #2;

        // Clean reset release, then one with a nonzero result.
        apply_reset();
        check("reset_viol", 64'(viol), 64'(0));
        check("reset_pair_state", 64'(pair_state), 64'(0));
        step();
        check("rst_val_clean", 64'(viol[1]), 64'(0));
        res = 16'h0001;
        apply_reset();
        step();
        check("rst_val_fire", 64'(viol[1]), 64'(1));
        check("rst_val_cnt", 64'(viol_cnt[CNW +: CNW]), 64'(1));
        step();
        check("rst_val_once", 64'(viol[1]), 64'(0));
        res = '0;
        step();

        // Pair completes after 15 idle ce cycles; times out after 16.
        mode = 1; cmd = 0; inp_valid = 2'b01;
        step();
        check("pair_enter_wait_b", 64'(pair_state), 64'(2));
        inp_valid = 2'b00;
        repeat (15) step();
        check("pair_still_waiting", 64'(pair_state), 64'(2));
        inp_valid = 2'b10;
        step();
        check("pair_done_state", 64'(pair_state), 64'(0));
        check("pair_done_viol", 64'(viol), 64'(0));
        inp_valid = 2'b01;
        step();
        inp_valid = 2'b00;
        repeat (15) step();
        check("timeout_not_yet", 64'(viol[2]), 64'(0));
        step();
        check("timeout_fire", 64'(viol[2]), 64'(1));
        check("timeout_idle", 64'(pair_state), 64'(0));

        // ce low freezes the wait; a cmd change aborts it.
        inp_valid = 2'b01;
        step();
        inp_valid = 2'b00; ce = 0;
        repeat (40) step();
        check("freeze_state", 64'(pair_state), 64'(2));
        ce = 1; inp_valid = 2'b10;
        step();
        check("freeze_done_viol", 64'(viol), 64'(0));
        check("freeze_done_state", 64'(pair_state), 64'(0));
        inp_valid = 2'b01;
        step();
        inp_valid = 2'b00; cmd = 1;
        step();
        check("cmd_change_fire", 64'(viol[3]), 64'(1));
        check("cmd_change_idle", 64'(pair_state), 64'(0));
        cmd = 0;
        step();

        // Output hold while ce is low.
        ce = 0; res = 16'h00A5;
        step();
        step();
        check("ce_hold_quiet", 64'(viol[0]), 64'(0));
        res = 16'h00A6;
        step();
        check("ce_hold_fire", 64'(viol[0]), 64'(1));
        ce = 1;
        step();

        // Illegal command must be answered by err.
        mode = 0; cmd = 14; inp_valid = 2'b11; err = 0;
        step();
        cmd = 0; inp_valid = 2'b00;
        step();
        check("err_missing_fire", 64'(viol[4]), 64'(1));
        cmd = 14; inp_valid = 2'b11;
        step();
        cmd = 0; inp_valid = 2'b00; err = 1;
        step();
        check("err_present_quiet", 64'(viol[4]), 64'(0));
        err = 0;
        step();

        // Counter saturation, then clear on a violating edge.
        ce = 0;
        repeat (305) begin
            res = ~res;
            step();
        end
        check("cnt_saturate", 64'(viol_cnt[0 +: CNW]), 64'(CNT_MAX));
        clr_sticky = 1; res = ~res;
        step();
        check("clr_sticky_flag", 64'(viol_sticky[0]), 64'(1));
        check("clr_sticky_cnt", 64'(viol_cnt[0 +: CNW]), 64'(1));
        clr_sticky = 0; ce = 1;
        step();

        // Randomized traffic against the model.
        repeat (3000) begin
            if ($urandom_range(299) == 0) apply_reset();
            ce = ($urandom_range(9) < 8);
            if ($urandom_range(9) == 0) begin
                mode = 1'($urandom);
                cmd  = CW'($urandom);
            end
            inp_valid = ($urandom_range(9) < 7) ? 2'b00 : 2'($urandom);
            opa = DW'($urandom);
            opb = DW'($urandom);
            cin = 1'($urandom);
            if ($urandom_range(3) == 0) res = RW'($urandom);
            if ($urandom_range(4) == 0) {cout, oflow, g, l, e} = 5'($urandom);
            err = 1'($urandom);
            clr_sticky = ($urandom_range(49) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_protocol_checker.md
# alu_protocol_checker

Synthesizable, parametrised protocol checker that sits alongside the ALU DUT on the same `clk`/`rst`, sampling every DUT input and output. Tracks operand-pairing, clock-enable hold, post-reset output values and illegal-command error reporting with a small FSM and per-check counters. Replaces simulation-only assertions with registered violation pulses, sticky flags and saturating counters. The same checks are usable in emulation, FPGA prototypes and UVM scoreboards.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width
- `CMD_WIDTH`, 4, command width
- `RES_WIDTH`, 2*DATA_WIDTH, DUT result width
- `TIMEOUT`, 16, ce-qualified cycles allowed for the second operand; legal range 1..255
- `CNT_WIDTH`, 8, width of each violation counter

Ports:
- `clk` in 1: single clock, all sampling on rising edge
- `rst` in 1: asynchronous, active-high reset, shared with DUT
- `ce`, `mode`, `cin` in 1 each: DUT inputs
- `opa`, `opb` in DATA_WIDTH: DUT operands
- `inp_valid` in 2: bit0 = opa valid, bit1 = opb valid
- `cmd` in CMD_WIDTH: DUT command
- `res` in RES_WIDTH: DUT result
- `cout`, `oflow`, `g`, `l`, `e`, `err` in 1 each: DUT flags
- `clr_sticky` in 1: synchronous clear of sticky flags and counters
- `viol` out 5: one-cycle violation pulses; bit0 CE_HOLD, bit1 RST_VAL, bit2 PAIR_TIMEOUT, bit3 PAIR_CMD_CHANGE, bit4 ERR_MISSING
- `viol_sticky` out 5: OR-accumulated `viol`
- `viol_cnt` out 5*CNT_WIDTH: per-bit counters, bit k at [k*CNT_WIDTH +: CNT_WIDTH]
- `pair_state` out 2: FSM state, IDLE=0 WAIT_A=1 WAIT_B=2

## Operation
- "Out vector" means {res, cout, oflow, g, l, e, err}.
- Two-operand ops:
  - mode=1: cmd 0,1,2,3,8,9,10
  - mode=0: cmd 0..5,12,13
- Illegal cmd: mode=1 with cmd>10, or mode=0 with cmd>13.
- CE_HOLD:
  - Applies when `ce`=0 was sampled at edge n, edge n was not the first post-reset edge, and `rst` was low.
  - The out vector at edge n+1 must equal the out vector at edge n. Any bit differing fires CE_HOLD at edge n+1.
- RST_VAL: at the first edge after `rst` deasserts, the out vector must be all zero; otherwise fire. Only that one edge is checked.
- Pairing FSM:
  - IDLE:
    - Requires `ce`=1 and a two-operand op.
    - inp_valid=01 → WAIT_B; 10 → WAIT_A. Capture mode/cmd and clear `wait_cnt`.
    - 11 or 00 → stay.
  - WAIT_A / WAIT_B, evaluated on edges with `ce`=1 only (ce=0 freezes state and counter). Priority order:
    1. mode/cmd differ from captured → PAIR_CMD_CHANGE, go to IDLE.
    2. The awaited valid bit is set → IDLE, no violation.
    3. `wait_cnt`==TIMEOUT-1 → PAIR_TIMEOUT, go to IDLE.
    4. Otherwise increment `wait_cnt`.
  - Leaving to IDLE does not re-evaluate the same edge as a new IDLE entry.
- ERR_MISSING: if edge n sampled `ce`=1, inp_valid≠00 and an illegal cmd, then `err` must be 1 at edge n+1; otherwise fire at n+1. Checks pipeline: a new illegal cmd at n+1 is checked at n+2.
- Sticky/counters:
  - Each `viol` bit ORs into `viol_sticky` and increments its counter.
  - Counters saturate at all-ones.
  - `clr_sticky` with a simultaneous violation: the clear applies first, so the result is sticky=1 and count=1.
- Multiple `viol` bits may fire on the same edge.

## Timing
- Reset values: `viol`=0, `viol_sticky`=0, all counters 0, `pair_state`=IDLE, internal history invalid.
- Reset asserted mid-WAIT: immediate return to IDLE, no violation.
- `viol` is registered. A check detected at edge n drives the pulse during cycle n→n+1. `viol_sticky` and counters reflect that violation in the same cycle.
- `pair_state` updates at the deciding edge.
- `TIMEOUT`=1: the first ce cycle without the awaited operand times out.

## Test plan
- Reset release with DUT res=0x0000 and all flags 0 → no `viol`. Repeat with res=0x0001 → `viol[1]` pulses once, `viol_cnt[1]`=1.
- mode=1, cmd=0, inp_valid=01 with ce=1, then 15 ce cycles of 00, then 10 → FSM IDLE→WAIT_B→IDLE, no violation. Same with 16 cycles of 00 → `viol[2]` on the 16th, `pair_state`=IDLE.
- In WAIT_B, hold ce=0 for 40 cycles, then 10 → no timeout. In WAIT_B, change cmd 0→1 → `viol[3]`, IDLE.
- ce=0 with res held at 0x00A5 → no violation; res changes to 0x00A6 while ce=0 → `viol[0]` next edge.
- mode=0, cmd=14, inp_valid=11, ce=1, DUT err=0 next cycle → `viol[4]`. Same with err=1 → none.
- Force 300 CE_HOLD violations with CNT_WIDTH=8 → counter stays 255. Assert `clr_sticky` on a violating edge → sticky=1, count=1.
